// File: rtl/tv_pkg.sv
// Shared TV-path definitions: pixel field widths, 4:2:2 upsampler states and defaults.
package tv_pkg;

  localparam int Y_W            = 8;
  localparam int C_W            = 8;
  localparam int X_W            = 10;
  localparam int LINE_W         = 10;
  localparam int FLUSH_IDLE_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } c422_state_e;

  typedef struct packed {
    logic [Y_W-1:0] y;
    logic [C_W-1:0] cb;
    logic [C_W-1:0] cr;
  } pix444_t;

  // One complete 4:2:2 pair: two lumas sharing one Cb/Cr sample.
  typedef struct packed {
    logic [Y_W-1:0] y0;
    logic [Y_W-1:0] y1;
    logic [C_W-1:0] cb;
    logic [C_W-1:0] cr;
  } pair_t;

endpackage

// File: rtl/chroma_avg.sv
// Combinational rounded average of two chroma samples: (a + b + 1) >> 1, 9-bit sum.
module chroma_avg
  import tv_pkg::*;
(
  input  logic [C_W-1:0] a_i,
  input  logic [C_W-1:0] b_i,
  output logic [C_W-1:0] avg_o
);

  localparam logic [C_W:0] ROUND = (C_W+1)'(1);

  logic [C_W:0] sum;

  assign sum   = {1'b0, a_i} + {1'b0, b_i} + ROUND;
  assign avg_o = C_W'(sum >> 1);

endmodule

// File: rtl/ycbcr422_to_444.sv
// 4:2:2 {Y,C} stream to 4:4:4 {Y,Cb,Cr} with horizontal chroma interpolation,
// output pixel X regeneration and idle-timeout flush of the line tail.
module ycbcr422_to_444
  import tv_pkg::*;
#(
  parameter int FLUSH_IDLE = FLUSH_IDLE_DEF
) (
  input  logic                   iCLK_27,
  input  logic                   iRST_N,
  input  logic [Y_W+C_W-1:0]     iYCbCr,
  input  logic                   iDVAL,
  input  logic [LINE_W-1:0]      iTV_Y,
  output logic [Y_W+2*C_W-1:0]   oYCbCr,
  output logic                   oDVAL,
  output logic [X_W-1:0]         oTV_X,
  output logic [LINE_W-1:0]      oTV_Y,
  output logic                   oERR
);

  localparam int                CNT_W   = $clog2(FLUSH_IDLE + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(FLUSH_IDLE);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [X_W-1:0]    X_ONE   = X_W'(1);

  c422_state_e          state_q, state_d;
  logic                 phase_q, phase_d;
  logic [CNT_W-1:0]     idle_cnt_q, idle_cnt_d;
  logic [Y_W-1:0]       y_ev_q, y_ev_d;
  logic [C_W-1:0]       cb_ev_q, cb_ev_d;
  pair_t                pair_q, pair_d;
  logic                 emit_even_q, emit_even_d;
  logic                 hold_vld_q, hold_vld_d;
  logic [Y_W+C_W-1:0]   hold_dat_q, hold_dat_d;
  logic [LINE_W-1:0]    hold_tvy_q, hold_tvy_d;
  pix444_t              out_q, out_d;
  logic                 out_vld_q, out_vld_d;
  logic [X_W-1:0]       x_q, x_d;
  logic [LINE_W-1:0]    tvy_q, tvy_d;
  logic                 err_q, err_d;

  logic                 flush_go;
  logic                 line_start;
  logic                 in_vld;
  logic [Y_W+C_W-1:0]   in_dat;
  logic [Y_W-1:0]       in_y;
  logic [C_W-1:0]       in_c;
  logic [LINE_W-1:0]    in_tvy;
  logic [C_W-1:0]       cb_mid;
  logic [C_W-1:0]       cr_mid;

  // A pixel caught in the flush-trigger cycle is replayed from the holding
  // register once the FSM is in FLUSH; iDVAL cannot also be high then.
  assign in_vld   = iDVAL | hold_vld_q;
  assign in_dat   = hold_vld_q ? hold_dat_q : iYCbCr;
  assign in_tvy   = hold_vld_q ? hold_tvy_q : iTV_Y;
  assign in_y     = in_dat[Y_W+C_W-1:C_W];
  assign in_c     = in_dat[C_W-1:0];

  assign flush_go = ((state_q == ST_FIRST) || (state_q == ST_RUN)) &&
                    (idle_cnt_q == CNT_MAX);

  // Odd pixel 2k-1 blends pair k-1 (held) with pair k (pending Cb, incoming Cr).
  chroma_avg u_cb_avg (
    .a_i   (pair_q.cb),
    .b_i   (cb_ev_q),
    .avg_o (cb_mid)
  );

  chroma_avg u_cr_avg (
    .a_i   (pair_q.cr),
    .b_i   (in_c),
    .avg_o (cr_mid)
  );

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    y_ev_d      = y_ev_q;
    cb_ev_d     = cb_ev_q;
    pair_d      = pair_q;
    emit_even_d = 1'b0;
    hold_vld_d  = 1'b0;
    hold_dat_d  = hold_dat_q;
    hold_tvy_d  = hold_tvy_q;
    out_d       = out_q;
    out_vld_d   = 1'b0;
    tvy_d       = tvy_q;
    err_d       = err_q;
    line_start  = 1'b0;

    if (iDVAL) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q == CNT_MAX) begin
      idle_cnt_d = idle_cnt_q;
    end else begin
      idle_cnt_d = idle_cnt_q + CNT_ONE;
    end

    case (state_q)
      ST_IDLE, ST_FLUSH: begin
        state_d = ST_IDLE;
        if (in_vld) begin
          state_d    = ST_FIRST;
          line_start = 1'b1;
          phase_d    = 1'b1;
          y_ev_d     = in_y;
          cb_ev_d    = in_c;
          tvy_d      = in_tvy;
        end
      end

      ST_FIRST, ST_RUN: begin
        if (flush_go) begin
          state_d    = ST_FLUSH;
          phase_d    = 1'b0;
          hold_vld_d = iDVAL;
          hold_dat_d = iYCbCr;
          hold_tvy_d = iTV_Y;
          if (state_q == ST_RUN) begin
            out_vld_d = 1'b1;
            out_d.y   = pair_q.y1;
            out_d.cb  = pair_q.cb;
            out_d.cr  = pair_q.cr;
          end
          // A lone pixel 0, or an even pixel still waiting for its Cr, is lost.
          if ((state_q == ST_FIRST) || phase_q) begin
            err_d = 1'b1;
          end
        end else begin
          if (emit_even_q) begin
            out_vld_d = 1'b1;
            out_d.y   = pair_q.y0;
            out_d.cb  = pair_q.cb;
            out_d.cr  = pair_q.cr;
          end
          if (in_vld) begin
            if (!phase_q) begin
              phase_d = 1'b1;
              y_ev_d  = in_y;
              cb_ev_d = in_c;
            end else begin
              phase_d   = 1'b0;
              state_d   = ST_RUN;
              out_vld_d = 1'b1;
              if (state_q == ST_FIRST) begin
                out_d.y  = y_ev_q;
                out_d.cb = cb_ev_q;
                out_d.cr = in_c;
              end else begin
                out_d.y     = pair_q.y1;
                out_d.cb    = cb_mid;
                out_d.cr    = cr_mid;
                emit_even_d = 1'b1;
              end
              pair_d.y0 = y_ev_q;
              pair_d.y1 = in_y;
              pair_d.cb = cb_ev_q;
              pair_d.cr = in_c;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (line_start) begin
      x_d = '0;
    end else if (out_vld_q) begin
      x_d = x_q + X_ONE;
    end else begin
      x_d = x_q;
    end
  end

  always_ff @(posedge iCLK_27 or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= ST_IDLE;
      phase_q     <= 1'b0;
      idle_cnt_q  <= '0;
      y_ev_q      <= '0;
      cb_ev_q     <= '0;
      pair_q      <= '0;
      emit_even_q <= 1'b0;
      hold_vld_q  <= 1'b0;
      hold_dat_q  <= '0;
      hold_tvy_q  <= '0;
      out_q       <= '0;
      out_vld_q   <= 1'b0;
      x_q         <= '0;
      tvy_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      idle_cnt_q  <= idle_cnt_d;
      y_ev_q      <= y_ev_d;
      cb_ev_q     <= cb_ev_d;
      pair_q      <= pair_d;
      emit_even_q <= emit_even_d;
      hold_vld_q  <= hold_vld_d;
      hold_dat_q  <= hold_dat_d;
      hold_tvy_q  <= hold_tvy_d;
      out_q       <= out_d;
      out_vld_q   <= out_vld_d;
      x_q         <= x_d;
      tvy_q       <= tvy_d;
      err_q       <= err_d;
    end
  end

  assign oYCbCr = out_q;
  assign oDVAL  = out_vld_q;
  assign oTV_X  = x_q;
  assign oTV_Y  = tvy_q;
  assign oERR   = err_q;

endmodule

// File: tb/tb_ycbcr422_to_444.sv
// Directed self-checking bench for ycbcr422_to_444 with hand-computed outputs.
module tb_ycbcr422_to_444;

  localparam int FLUSH_IDLE = 16;

  logic        iCLK_27;
  logic        iRST_N;
  logic [15:0] iYCbCr;
  logic        iDVAL;
  logic [9:0]  iTV_Y;
  logic [23:0] oYCbCr;
  logic        oDVAL;
  logic [9:0]  oTV_X;
  logic [9:0]  oTV_Y;
  logic        oERR;

  int compared = 0;
  int failed   = 0;
  int cyc      = 0;
  int last_acc = 0;

  logic [23:0] cap_pix [$];
  int          cap_x   [$];
  int          cap_y   [$];
  int          cap_c   [$];

  ycbcr422_to_444 #(.FLUSH_IDLE(FLUSH_IDLE)) dut (
    .iCLK_27 (iCLK_27),
    .iRST_N  (iRST_N),
    .iYCbCr  (iYCbCr),
    .iDVAL   (iDVAL),
    .iTV_Y   (iTV_Y),
    .oYCbCr  (oYCbCr),
    .oDVAL   (oDVAL),
    .oTV_X   (oTV_X),
    .oTV_Y   (oTV_Y),
    .oERR    (oERR)
  );

  initial iCLK_27 = 1'b0;
  always #5 iCLK_27 = ~iCLK_27;

  always @(posedge iCLK_27) cyc <= cyc + 1;

  always @(negedge iCLK_27) begin
    if (oDVAL === 1'b1) begin
      cap_pix.push_back(oYCbCr);
      cap_x.push_back(int'(oTV_X));
      cap_y.push_back(int'(oTV_Y));
      cap_c.push_back(cyc);
    end
  end

  task automatic clear_caps();
    cap_pix.delete();
    cap_x.delete();
    cap_y.delete();
    cap_c.delete();
  endtask

  task automatic do_reset();
    iRST_N = 1'b0;
    iDVAL  = 1'b0;
    iYCbCr = 16'h0;
    iTV_Y  = 10'd0;
    repeat (3) @(posedge iCLK_27);
    #1 iRST_N = 1'b1;
    clear_caps();
  endtask

  task automatic send_pix(input logic [15:0] d, input logic [9:0] ty);
    @(posedge iCLK_27);
    #1;
    iYCbCr   = d;
    iTV_Y    = ty;
    iDVAL    = 1'b1;
    last_acc = cyc;
    @(posedge iCLK_27);
    #1 iDVAL = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge iCLK_27);
  endtask

  task automatic gap(input int g);
    repeat (g - 1) @(posedge iCLK_27);
  endtask

  task automatic test_reset();
    do_reset();
    compared++;
    if ({oYCbCr, oDVAL, oTV_X, oTV_Y, oERR} !== 46'h0) begin
      failed++;
      $display("FAIL reset_outputs: got pix=%h dval=%b x=%0d y=%0d err=%b want all zero",
               oYCbCr, oDVAL, oTV_X, oTV_Y, oERR);
    end
  endtask

  task automatic test_four_pixel();
    logic [23:0] exp_pix [4] = '{24'h101020, 24'h202030, 24'h303040, 24'h403040};
    int exp_c [4];
    int acc1, acc3;
    do_reset();
    send_pix(16'h1010, 10'd5);
    send_pix(16'h2020, 10'd5);
    acc1 = last_acc;
    send_pix(16'h3030, 10'd5);
    send_pix(16'h4040, 10'd5);
    acc3 = last_acc;
    idle(40);
    exp_c = '{acc1 + 1, acc3 + 1, acc3 + 2, acc3 + FLUSH_IDLE + 2};
    compared++;
    if (cap_pix.size() != 4) begin
      failed++;
      $display("FAIL four_count: got %0d want 4", cap_pix.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < cap_pix.size()) begin
        compared++;
        if (cap_pix[i] !== exp_pix[i]) begin
          failed++;
          $display("FAIL four_pix[%0d]: got %h want %h", i, cap_pix[i], exp_pix[i]);
        end
        compared++;
        if (cap_x[i] != i || cap_y[i] != 5) begin
          failed++;
          $display("FAIL four_xy[%0d]: got x=%0d y=%0d want x=%0d y=5", i, cap_x[i], cap_y[i], i);
        end
        compared++;
        if (cap_c[i] != exp_c[i]) begin
          failed++;
          $display("FAIL four_cycle[%0d]: got %0d want %0d", i, cap_c[i], exp_c[i]);
        end
      end
    end
    compared++;
    if (oERR !== 1'b0) begin
      failed++;
      $display("FAIL four_err: got %b want 0", oERR);
    end
  endtask

  task automatic test_rounding();
    do_reset();
    send_pix(16'h1101, 10'd1);
    send_pix(16'h2205, 10'd1);
    send_pix(16'h3302, 10'd1);
    send_pix(16'h4407, 10'd1);
    idle(40);
    compared++;
    if (cap_pix.size() != 4 || cap_pix[1] !== 24'h220206) begin
      failed++;
      $display("FAIL round_small: got n=%0d pix1=%h want n=4 pix1=220206",
               cap_pix.size(), (cap_pix.size() > 1) ? cap_pix[1] : 24'hx);
    end
    do_reset();
    send_pix(16'h55FF, 10'd1);
    send_pix(16'h6600, 10'd1);
    send_pix(16'h77FF, 10'd1);
    send_pix(16'h88FF, 10'd1);
    idle(40);
    compared++;
    if (cap_pix.size() != 4 || cap_pix[1] !== 24'h66FF80) begin
      failed++;
      $display("FAIL round_max: got n=%0d pix1=%h want n=4 pix1=66ff80",
               cap_pix.size(), (cap_pix.size() > 1) ? cap_pix[1] : 24'hx);
    end
  endtask

  task automatic test_long_line();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 720; i++) begin
      send_pix({8'(i), 8'h80}, 10'd100);
    end
    gap(276);
    send_pix(16'h1010, 10'd101);
    send_pix(16'h2020, 10'd101);
    idle(40);
    compared++;
    if (cap_pix.size() != 722) begin
      failed++;
      $display("FAIL long_count: got %0d want 722", cap_pix.size());
    end else begin
      for (int i = 0; i < 720; i++) begin
        if (cap_pix[i] !== {8'(i), 16'h8080} || cap_x[i] != i || cap_y[i] != 100) bad++;
      end
      compared++;
      if (bad != 0) begin
        failed++;
        $display("FAIL long_pixels: got %0d bad pixels want 0", bad);
      end
      compared++;
      if (cap_x[719] != 719) begin
        failed++;
        $display("FAIL long_last_x: got %0d want 719", cap_x[719]);
      end
      compared++;
      if (cap_pix[720] !== 24'h101020 || cap_x[720] != 0 || cap_y[720] != 101) begin
        failed++;
        $display("FAIL long_second_line: got pix=%h x=%0d y=%0d want 101020 x=0 y=101",
                 cap_pix[720], cap_x[720], cap_y[720]);
      end
    end
  endtask

  task automatic test_short_lines();
    do_reset();
    send_pix(16'h1010, 10'd9);
    send_pix(16'h2020, 10'd9);
    send_pix(16'h3030, 10'd9);
    idle(40);
    compared++;
    if (cap_pix.size() != 2 || cap_pix[0] !== 24'h101020 || cap_pix[1] !== 24'h201020 ||
        cap_x[1] != 1) begin
      failed++;
      $display("FAIL three_pix: got n=%0d want 2 pixels 101020,201020 x=0,1", cap_pix.size());
    end
    compared++;
    if (oERR !== 1'b1) begin
      failed++;
      $display("FAIL three_err: got %b want 1", oERR);
    end
    do_reset();
    send_pix(16'h1111, 10'd9);
    idle(40);
    compared++;
    if (cap_pix.size() != 0 || oERR !== 1'b1) begin
      failed++;
      $display("FAIL single_pix: got n=%0d err=%b want n=0 err=1", cap_pix.size(), oERR);
    end
  endtask

  task automatic test_reset_midline();
    do_reset();
    send_pix(16'h1010, 10'd7);
    send_pix(16'h2020, 10'd7);
    send_pix(16'h3030, 10'd7);
    send_pix(16'h4040, 10'd7);
    send_pix(16'h5050, 10'd7);
    send_pix(16'h6060, 10'd7);
    compared++;
    if (oDVAL !== 1'b1 || oYCbCr !== 24'h404050 || oTV_X !== 10'd3 || oTV_Y !== 10'd7) begin
      failed++;
      $display("FAIL midline_pre: got dval=%b pix=%h x=%0d y=%0d want 1 404050 3 7",
               oDVAL, oYCbCr, oTV_X, oTV_Y);
    end
    iRST_N = 1'b0;
    #1;
    clear_caps();
    @(negedge iCLK_27);
    compared++;
    if ({oYCbCr, oDVAL, oTV_X, oTV_Y, oERR} !== 46'h0) begin
      failed++;
      $display("FAIL midline_reset: got pix=%h dval=%b x=%0d y=%0d err=%b want all zero",
               oYCbCr, oDVAL, oTV_X, oTV_Y, oERR);
    end
    iRST_N = 1'b1;
    idle(40);
    compared++;
    if (cap_pix.size() != 0) begin
      failed++;
      $display("FAIL midline_quiet: got %0d outputs want 0", cap_pix.size());
    end
  endtask

  task automatic test_gap_boundary();
    logic [23:0] exp_b [6] = '{24'h101020, 24'h202030, 24'h303040, 24'h403040,
                               24'h505060, 24'h605060};
    int exp_bx [6] = '{0, 1, 2, 3, 0, 1};
    int exp_by [6] = '{3, 3, 3, 3, 4, 4};
    do_reset();
    send_pix(16'h1010, 10'd3);
    send_pix(16'h2020, 10'd3);
    gap(FLUSH_IDLE - 1);
    send_pix(16'h3030, 10'd3);
    send_pix(16'h4040, 10'd3);
    idle(40);
    compared++;
    if (cap_pix.size() != 4 || cap_pix[1] !== 24'h202030 || cap_x[3] != 3) begin
      failed++;
      $display("FAIL gap_short: got n=%0d want 4 pixels, pix1=202030, x3=3", cap_pix.size());
    end
    do_reset();
    send_pix(16'h1010, 10'd3);
    send_pix(16'h2020, 10'd3);
    send_pix(16'h3030, 10'd3);
    send_pix(16'h4040, 10'd3);
    gap(FLUSH_IDLE);
    send_pix(16'h5050, 10'd4);
    send_pix(16'h6060, 10'd4);
    idle(40);
    compared++;
    if (cap_pix.size() != 6) begin
      failed++;
      $display("FAIL gap_exact_count: got %0d want 6", cap_pix.size());
    end
    for (int i = 0; i < 6; i++) begin
      if (i < cap_pix.size()) begin
        compared++;
        if (cap_pix[i] !== exp_b[i] || cap_x[i] != exp_bx[i] || cap_y[i] != exp_by[i]) begin
          failed++;
          $display("FAIL gap_exact[%0d]: got pix=%h x=%0d y=%0d want %h x=%0d y=%0d",
                   i, cap_pix[i], cap_x[i], cap_y[i], exp_b[i], exp_bx[i], exp_by[i]);
        end
      end
    end
    compared++;
    if (oERR !== 1'b0) begin
      failed++;
      $display("FAIL gap_exact_err: got %b want 0", oERR);
    end
  endtask

  initial begin
    iRST_N = 1'b0;
    iDVAL  = 1'b0;
    iYCbCr = 16'h0;
    iTV_Y  = 10'd0;
    test_reset();
    test_four_pixel();
    test_rounding();
    test_short_lines();
    test_reset_midline();
    test_gap_boundary();
    test_long_line();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
